// File: rtl/npu_pkg.sv
// Shared NPU definitions: activation opcodes and the fixed-point unit constant.
package npu_pkg;

  typedef enum logic [1:0] {
    ACT_PASS    = 2'b00,
    ACT_RELU    = 2'b01,
    ACT_TANH    = 2'b10,
    ACT_SIGMOID = 2'b11
  } act_op_t;

  localparam int FX_OF  = 19;
  localparam int ONE_FX = 1 << FX_OF;

endpackage

// File: rtl/tanh.sv
// Fixed-latency tanh approximation: sign(x) * (|x| - x^2/4) for |x| < 2, saturating to +/-1.0 beyond.
module tanh #(
  parameter int    DW          = 32,
  parameter int    OF          = 19,
  parameter int    LAT         = 3,
  parameter string RTL_DIR     = "rtl",
  parameter bit    TARGET_FPGA = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] x,
  output logic [DW-1:0] t
);

  localparam logic [DW-1:0] ONE = DW'(1) << OF;
  localparam logic [DW-1:0] TWO = DW'(2) << OF;
  // FPGA builds from a real source tree fold the clear into the flop's synchronous reset pin.
  localparam bit SYNC_CLR = TARGET_FPGA && (RTL_DIR != "");

  logic            neg;
  logic [DW-1:0]   ax;
  logic [2*DW-1:0] sq;
  logic [DW-1:0]   mag;
  logic [DW-1:0]   y;
  logic [DW-1:0]   pipe [LAT];

  // NOTE: every variable here is assigned on every path, so no latch is inferred.
  always_comb begin
    neg = x[DW-1];
    ax  = neg ? -x : x;
    sq  = {{DW{1'b0}}, ax} * {{DW{1'b0}}, ax};
    mag = (ax >= TWO) ? ONE : ax - DW'(sq >> (OF + 2));
    y   = neg ? -mag : mag;
  end

  if (SYNC_CLR) begin : g_sync_clr
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= y;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
    end
  end else begin : g_async_clr
    // NOTE: state uses non-blocking assignments so every stage samples the pre-edge value.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LAT; i++) pipe[i] <= '0;
      end else begin
        pipe[0] <= y;
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
      end
    end
  end

  assign t = pipe[LAT-1];

endmodule

// File: rtl/act_stage.sv
// Activation stage: fixed-latency pass/relu/tanh/sigmoid pipeline feeding a credit-guarded FWFT FIFO.
module act_stage
  import npu_pkg::*;
#(
  parameter int    DW          = 32,
  parameter int    OF          = $clog2(ONE_FX),
  parameter int    DEPTH       = 8,
  parameter int    TANH_LAT    = 3,
  parameter string RTL_DIR     = "rtl",
  parameter bit    TARGET_FPGA = 1'b0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [1:0]    in_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int OCC_W = $clog2(DEPTH + TANH_LAT + 3);
  localparam logic [DW-1:0] HALF = DW'(1) << (OF - 1);

  logic                accept;
  logic                push;
  logic                pop;
  logic                s0_valid;
  logic [DW-1:0]       s0_x;
  act_op_t             s0_op;
  logic [TANH_LAT-1:0] d_valid;
  logic [DW-1:0]       d_x  [TANH_LAT];
  act_op_t             d_op [TANH_LAT];
  logic                post_valid;
  logic [DW-1:0]       post_data;
  logic [DW-1:0]       post_next;
  logic [DW-1:0]       tanh_in;
  logic [DW-1:0]       tanh_out;
  logic [DW-1:0]       mem  [DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [CW-1:0]       count;
  logic [OCC_W-1:0]    occupancy;

  assign accept    = in_valid && in_ready;
  assign push      = post_valid;
  assign pop       = out_valid && out_ready;
  assign out_valid = (count != '0);
  assign out_data  = out_valid ? mem[rd_ptr] : '0;

  // Credits cover every word already accepted, so a FIFO write can never meet a full FIFO.
  always_comb begin
    occupancy = OCC_W'(count) + OCC_W'(s0_valid) + OCC_W'(post_valid);
    for (int i = 0; i < TANH_LAT; i++) occupancy = occupancy + OCC_W'(d_valid[i]);
  end

  assign in_ready = occupancy < OCC_W'(DEPTH);

  always_comb begin
    tanh_in = s0_x;
    if (s0_op == ACT_SIGMOID) tanh_in = {s0_x[DW-1], s0_x[DW-1:1]};
  end

  always_comb begin
    post_next = d_x[TANH_LAT-1];
    case (d_op[TANH_LAT-1])
      ACT_RELU:    if (d_x[TANH_LAT-1][DW-1]) post_next = '0;
      ACT_TANH:    post_next = tanh_out;
      ACT_SIGMOID: post_next = {tanh_out[DW-1], tanh_out[DW-1:1]} + HALF;
      default:     ;
    endcase
  end

  tanh #(
    .DW          (DW),
    .OF          (OF),
    .LAT         (TANH_LAT),
    .RTL_DIR     (RTL_DIR),
    .TARGET_FPGA (TARGET_FPGA)
  ) u_tanh (
    .clk (clk),
    .rst (rst),
    .x   (tanh_in),
    .t   (tanh_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid   <= 1'b0;
      d_valid    <= '0;
      post_valid <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      s0_valid <= accept;
      d_valid[0] <= s0_valid;
      for (int i = 1; i < TANH_LAT; i++) d_valid[i] <= d_valid[i-1];
      post_valid <= d_valid[TANH_LAT-1];
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // NOTE: payload and FIFO storage carry no reset; the valid bits and count decide what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      s0_x  <= in_data;
      s0_op <= act_op_t'(in_op);
    end
    d_x[0]  <= s0_x;
    d_op[0] <= s0_op;
    for (int i = 1; i < TANH_LAT; i++) begin
      d_x[i]  <= d_x[i-1];
      d_op[i] <= d_op[i-1];
    end
    post_data <= post_next;
    if (push) mem[wr_ptr] <= post_data;
  end

endmodule

// File: tb/tb_act_stage.sv
// Scoreboard bench for act_stage: directed vectors, backpressure, mid-stream reset and random out_ready streaming.
`timescale 1ns/1ps
module tb_act_stage;
  import npu_pkg::*;

  localparam int DW      = 32;
  localparam int DEPTH   = 8;
  localparam int LATENCY = 5;
  localparam int NV      = 12;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] acc_cyc;
    logic        chk_lat;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic [1:0]    in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] cyc = '0;
  int          acc = 0;
  int          pops = 0;
  logic [31:0] cur_exp = '0;
  logic        cur_lat = 1'b0;
  logic        credit_chk = 1'b0;
  exp_t        q[$];
  exp_t        mon_e;

  // Hand-computed vectors: op, operand, expected activation (Q12.19).
  logic [1:0]  v_op [NV] = '{ACT_PASS, ACT_RELU, ACT_TANH, ACT_TANH, ACT_SIGMOID, ACT_SIGMOID,
                              ACT_RELU, ACT_PASS, ACT_TANH, ACT_SIGMOID, ACT_TANH, ACT_RELU};
  logic [31:0] v_x  [NV] = '{32'h12345678, 32'hFFFFFFFB, 32'h00280000, 32'hFFD80000,
                              32'h00000000, 32'h00500000, 32'h00001234, 32'h80000000,
                              32'h00000000, 32'hFFB00000, 32'h80000000, 32'h7FFFFFFF};
  logic [31:0] v_e  [NV] = '{32'h12345678, 32'h00000000, 32'h00080000, 32'hFFF80000,
                              32'h00040000, 32'h00080000, 32'h00001234, 32'h80000000,
                              32'h00000000, 32'h00000000, 32'hFFF80000, 32'h7FFFFFFF};

  act_stage dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitor: records accepts into the scoreboard and compares every popped word.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      q.delete();
      acc  = 0;
      pops = 0;
    end else begin
      if (credit_chk) check("credit", 32'(in_ready), 32'((acc - pops) < DEPTH));
      if (in_valid && in_ready) begin
        mon_e.data    = cur_exp;
        mon_e.acc_cyc = cyc + 32'd1;
        mon_e.chk_lat = cur_lat;
        q.push_back(mon_e);
        acc++;
      end
      if (out_valid && out_ready) begin
        pops++;
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=0x%08h required=none", out_data);
        end else begin
          mon_e = q.pop_front();
          check("out_data", out_data, mon_e.data);
          if (mon_e.chk_lat) check("latency", cyc - mon_e.acc_cyc, LATENCY);
        end
      end
    end
  end

  task automatic load(input int idx, input logic lat);
    in_op   = v_op[idx];
    in_data = v_x[idx];
    cur_exp = v_e[idx];
    cur_lat = lat;
  endtask

  task automatic send(input int idx, input logic lat);
    int n = 0;
    load(idx, lat);
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=accept idx=%0d", idx);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n = 0;
    while ((q.size() != 0 || out_valid) && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    if (q.size() != 0 || out_valid) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", q.size());
    end
  endtask

  initial begin
    int nacc;
    int idx;
    logic stale;
    logic took;

    #1 rst = 1'b1;
    #11;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", out_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("ready_after_rst", 32'(in_ready), 32'd1);

    // Directed pass/relu, tanh saturation, sigmoid with exact latency.
    out_ready = 1'b1;
    send(0, 1'b1); send(1, 1'b1); wait_drain(50);
    send(2, 1'b1); send(3, 1'b1); wait_drain(50);
    send(4, 1'b1); send(5, 1'b1); wait_drain(50);
    send(10, 1'b1); send(9, 1'b1); send(7, 1'b1); wait_drain(50);

    // Backpressure: hold in_valid for 20 cycles with the consumer stalled.
    out_ready  = 1'b0;
    credit_chk = 1'b1;
    nacc = 0;
    for (int c = 0; c < 20; c++) begin
      load(nacc % NV, 1'b0);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_ready) nacc++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("bp_accepts", 32'(nacc), DEPTH);
    check("bp_ready_low", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_hold0", out_data, v_e[0]);
    @(posedge clk); #1;
    check("bp_hold1", out_data, v_e[0]);
    out_ready = 1'b1;
    wait_drain(100);
    check("bp_ready_high", 32'(in_ready), 32'd1);

    // Reset with 4 words buffered and 3 in flight.
    out_ready = 1'b0;
    send(6, 1'b0); send(7, 1'b0); send(8, 1'b0); send(9, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    send(10, 1'b0); send(11, 1'b0); send(0, 1'b0);
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out_data", out_data, 32'd0);
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("rst_mid_ready", 32'(in_ready), 32'd1);
    stale = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    check("no_stale_output", 32'(stale), 32'd0);
    @(posedge clk); #1;
    send(2, 1'b1);
    wait_drain(50);

    // Streaming with random valid gaps and random out_ready.
    idx  = 0;
    took = 1'b0;
    for (int c = 0; c < 2000 && idx < 60; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (!in_valid || took) begin
        took = 1'b0;
        if ($urandom_range(0, 2) != 0) begin
          load(idx % NV, 1'b0);
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        took = 1'b1;
        idx++;
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", 32'(idx), 32'd60);
    wait_drain(300);
    credit_chk = 1'b0;
    check("final_ready", 32'(in_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/act_stage.md
ACT_STAGE -- requirements
Module: act_stage

Interface
REQ-001 Parameter DW, default 32, datapath width in bits, two's-complement fixed point.
REQ-002 Parameter OF, default 19, fraction bits; 1.0 = 2^OF = 524288.
REQ-003 Parameter DEPTH, default 8, output FIFO entries; power of two, min 8.
REQ-004 Parameter TANH_LAT, default 3, fixed latency of the tanh sub-unit in cycles.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 in_valid  input  1  upstream word valid.
REQ-008 in_ready  output  1  stage can accept a word this cycle.
REQ-009 in_data  input  DW  operand x.
REQ-010 in_op  input  2  function: 00 pass, 01 relu, 10 tanh, 11 sigmoid.
REQ-011 out_valid  output  1  result word available.
REQ-012 out_ready  input  1  downstream accepts result.
REQ-013 out_data  output  DW  activation result.

Function
REQ-014 A word SHALL be accepted on a rising edge where in_valid and in_ready are both 1; in_data/in_op are ignored otherwise.
REQ-015 Every accepted word SHALL traverse one fixed-length pipeline of 1 input register + TANH_LAT + 1 post register (5 stages at default) regardless of in_op, so results leave in acceptance order.
REQ-016 Tanh sub-unit operand: in_data for op 10; in_data arithmetically shifted right by 1 for op 11; don't-care for op 00/01.
REQ-017 Post stage: op 00 -> x; op 01 -> (x < 0 ? 0 : x); op 10 -> t; op 11 -> (t >>> 1) + 2^(OF-1); t is the tanh sub-unit result, x the delayed input.
REQ-018 All arithmetic SHALL be DW-bit, wrap on overflow; sigmoid result range [0, 2^OF] cannot overflow.
REQ-019 The post register SHALL write the FIFO on the edge after it holds a valid word; out_valid SHALL first be 1 after the 5th rising edge following acceptance when the FIFO was empty.
REQ-020 FIFO SHALL be first-word-fall-through: out_data valid whenever out_valid=1; pop on edge where out_valid and out_ready are 1.
REQ-021 The pipeline SHALL NOT stall; a per-stage valid bit shift register tracks occupancy.
REQ-022 Credit rule: in_ready = (fifo_count + inflight) < DEPTH, where inflight = number of valid pipeline stages; in_ready is combinational from registered counters only, never from in_valid or out_ready.
REQ-023 Simultaneous accept and pop in one cycle SHALL leave total occupancy unchanged; simultaneous FIFO write and pop on a full FIFO SHALL not occur by construction of REQ-022.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH; count range 0..DEPTH.
REQ-025 out_data SHALL hold its value while out_valid=1 and out_ready=0.

Reset
REQ-026 On rst assertion all valid bits, FIFO pointers, and counters SHALL clear immediately (asynchronously); in-flight and buffered words are discarded.
REQ-027 During and after reset: out_valid=0, in_ready=1 (once rst deasserts), out_data=0.
REQ-028 Datapath registers without valid meaning need no reset; the tanh sub-unit receives the same rst.

Structure
REQ-029 Shared package npu_pkg SHALL hold the act_op_t enum (ACT_PASS, ACT_RELU, ACT_TANH, ACT_SIGMOID) and the ONE_FX = 2^OF constant.
REQ-030 Exactly one sub-module: tanh, instantiated with DW, OF and the team's RTL_DIR/TARGET_FPGA parameters; FIFO and credit logic inline.

Verification
REQ-031 Pass/relu: ops 00 with 0x12345678 and 01 with 0xFFFFFFFB, out_ready=1 -> outputs 0x12345678 then 0x00000000, first at accept+5 cycles.
REQ-032 Tanh saturation: op 10 with 2621440 (5.0) then -2621440 -> 524288 then 0xFFF80000.
REQ-033 Sigmoid: op 11 with 0 -> 262144; op 11 with 5242880 (10.0) -> 524288.
REQ-034 Backpressure: out_ready=0, in_valid=1 for 20 cycles mixed ops -> exactly 8 accepted, in_ready low thereafter; out_ready=1 -> 8 results in order, in_ready returns high.
REQ-035 Reset mid-stream: assert rst with 3 words in flight and 4 in FIFO -> out_valid=0 same cycle, no stale word emitted after release, next accepted word emerges at accept+5.
REQ-036 Random streaming with random out_ready toggles against a golden model -> no loss, duplication or reordering; in_ready never low when occupancy < DEPTH.
